draw_sequencer: RTL

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_pkg.sv | 36 +++
 rtl/raster_counter.sv | 56 +++++
 rtl/draw_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer: FSM state encoding, colour width,
// requester IDs, default screen geometry and the round-robin arbitration rule.
package draw_pkg;

  localparam int COLOUR_W     = 3;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CLR = 1'b0,
    REQ_SPR = 1'b1
  } req_id_t;

  // Winner among pending requesters; on contention the one not granted last wins.
  function automatic req_id_t arbitrate(input logic clr, input logic spr, input req_id_t last);
    req_id_t win;
    if (clr && spr) begin
      win = (last == REQ_CLR) ? REQ_SPR : REQ_CLR;
    end else if (clr) begin
      win = REQ_CLR;
    end else begin
      win = REQ_SPR;
    end
    return win;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Nested raster offset counter: i runs 0..w-1 (inner), j runs 0..h-1 (outer).
// Extents are captured on load; last flags the final offset pair, or an empty
// (zero-width or zero-height) area so the scan terminates after one step.
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           en,
  input  logic [X_W-1:0] w_in,
  input  logic [Y_W-1:0] h_in,
  output logic [X_W-1:0] i,
  output logic [Y_W-1:0] j,
  output logic           last,
  output logic           empty
);

  logic [X_W-1:0] i_q, w_q;
  logic [Y_W-1:0] j_q, h_q;
  logic           empty_q;
  logic           i_end, j_end;

  assign i_end = (i_q == w_q - 1'b1);
  assign j_end = (j_q == h_q - 1'b1);
  assign last  = empty_q | (i_end & j_end);
  assign empty = empty_q;
  assign i     = i_q;
  assign j     = j_q;

  // Capture extents on load, then step x first and wrap into the next row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      empty_q <= 1'b0;
    end else if (load) begin
      i_q     <= '0;
      j_q     <= '0;
      w_q     <= w_in;
      h_q     <= h_in;
      empty_q <= (w_in == '0) || (h_in == '0);
    end else if (en) begin
      if (i_end) begin
        i_q <= '0;
        j_q <= j_q + 1'b1;
      end else begin
        i_q <= i_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Pixel draw sequencer: arbitrates a full-screen clear and a rectangle draw,
// then emits one pixel write per cycle in raster order.
// Build option: DRAW_CLIP_EN -- off-screen pixels are scanned with plot low
// instead of being written at coordinates truncated to the output width.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; the only state in which requests are sampled
// ST_CLEAR | scanning the whole screen with the latched clear colour
// ST_DRAW  | scanning the latched rectangle (one step if it is empty)
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_req,
  input  logic [COLOUR_W-1:0] clr_colour,
  input  logic                spr_req,
  input  logic [X_W-1:0]      spr_x,
  input  logic [Y_W-1:0]      spr_y,
  input  logic [X_W-1:0]      spr_w,
  input  logic [Y_W-1:0]      spr_h,
  input  logic [COLOUR_W-1:0] spr_colour,
  output logic                clr_gnt,
  output logic                spr_gnt,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  state_t              state_q, state_d;
  req_id_t             last_gnt_q, winner;
  logic                first_q, accept, scan_en, on_screen;
  logic [X_W-1:0]      base_x_q, rc_i, load_w;
  logic [Y_W-1:0]      base_y_q, rc_j, load_h;
  logic [COLOUR_W-1:0] colour_q;
  logic                rc_last, rc_empty;
  logic [X_W:0]        x_sum;
  logic [Y_W:0]        y_sum;

  assign winner = arbitrate(clr_req, spr_req, last_gnt_q);
  assign load_w = (winner == REQ_CLR) ? X_W'(SCREEN_W) : spr_w;
  assign load_h = (winner == REQ_CLR) ? Y_W'(SCREEN_H) : spr_h;

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (scan_en),
    .w_in  (load_w),
    .h_in  (load_h),
    .i     (rc_i),
    .j     (rc_j),
    .last  (rc_last),
    .empty (rc_empty)
  );

  // Sums carry one extra bit so an overflow past the screen edge is visible
  // to the clip test rather than silently wrapping first.
  assign x_sum = {1'b0, base_x_q} + {1'b0, rc_i};
  assign y_sum = {1'b0, base_y_q} + {1'b0, rc_j};
  assign x     = X_W'(x_sum);
  assign y     = Y_W'(y_sum);

`ifdef DRAW_CLIP_EN
  localparam logic [X_W:0] SCR_W_EXT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_EXT = (Y_W+1)'(SCREEN_H);
  assign on_screen = (x_sum < SCR_W_EXT) && (y_sum < SCR_H_EXT);
`else
  assign on_screen = 1'b1;
`endif

  assign clr_gnt = first_q && (state_q == ST_CLEAR);
  assign spr_gnt = first_q && (state_q == ST_DRAW);
  assign colour  = colour_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture at acceptance, first-cycle grant flag and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q    <= 1'b0;
      last_gnt_q <= REQ_SPR;
      base_x_q   <= '0;
      base_y_q   <= '0;
      colour_q   <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        last_gnt_q <= winner;
        if (winner == REQ_CLR) begin
          base_x_q <= '0;
          base_y_q <= '0;
          colour_q <= clr_colour;
        end else begin
          base_x_q <= spr_x;
          base_y_q <= spr_y;
          colour_q <= spr_colour;
        end
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    scan_en = 1'b0;
    plot    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req || spr_req) begin
          accept  = 1'b1;
          state_d = (winner == REQ_CLR) ? ST_CLEAR : ST_DRAW;
        end
      end
      ST_CLEAR, ST_DRAW: begin
        busy    = 1'b1;
        scan_en = 1'b1;
        plot    = !rc_empty && on_screen;
        if (rc_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
